// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite response codes, default widths and FSM state types
package axi_lite_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int RESP_WIDTH_DEF = 3;

    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_EXOKAY = 3'b001;
    localparam logic [2:0] RESP_SLVERR = 3'b010;
    localparam logic [2:0] RESP_DECERR = 3'b011;

    typedef enum logic {W_COLLECT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axi_lite_slave_mem_if.sv
// rtl/axi_lite_slave_mem_if.sv - AXI4-Lite channel bundle between a master and the memory responder
interface axi_lite_slave_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8:0]   s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [RESP_WIDTH-1:0]   s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [RESP_WIDTH-1:0]   s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axi_lite_strb_mem.sv
// rtl/axi_lite_strb_mem.sv - word array with byte-enable write, registered read and reset clear
module axi_lite_strb_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_WIDTH-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic                    rhit,
    input  logic [IDX_WIDTH-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Same-edge read of a word being written sees the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rhit ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/axi_lite_slave_mem.sv
// rtl/axi_lite_slave_mem.sv - AXI4-Lite responder terminating writes and reads into a small memory
module axi_lite_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int RESP_WIDTH = RESP_WIDTH_DEF,
    parameter int DEPTH      = 16,
    parameter int BASE_ADDR  = 0
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_areset,
    axi_lite_slave_mem_if.slave  bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [RESP_WIDTH-1:0] OKAY   = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(RESP_SLVERR);

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
        return (32'(addr) >= 32'(BASE_ADDR)) &&
               (32'((addr - ADDR_WIDTH'(BASE_ADDR)) >> BYTE_SHIFT) < 32'(DEPTH));
    endfunction

    function automatic logic [IDX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_WIDTH'((addr - ADDR_WIDTH'(BASE_ADDR)) >> BYTE_SHIFT);
    endfunction

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [RESP_WIDTH-1:0] bresp_q, rresp_q;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] cur_awaddr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [STRB_WIDTH-1:0] cur_wstrb;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_strb_msb;

    assign unused_strb_msb = bus.s_axi_wstrb[STRB_WIDTH];

    assign bus.s_axi_awready = !s_axi_areset && (w_state == W_COLLECT) && !aw_held;
    assign bus.s_axi_wready  = !s_axi_areset && (w_state == W_COLLECT) && !w_held;
    assign bus.s_axi_arready = !s_axi_areset && (r_state == R_IDLE);
    assign aw_hs = bus.s_axi_awvalid && bus.s_axi_awready;
    assign w_hs  = bus.s_axi_wvalid  && bus.s_axi_wready;
    assign ar_hs = bus.s_axi_arvalid && bus.s_axi_arready;

    // A channel arriving this cycle is used directly so the commit needs no extra cycle.
    assign cur_awaddr = aw_held ? awaddr_q : bus.s_axi_awaddr;
    assign cur_wdata  = w_held  ? wdata_q  : bus.s_axi_wdata;
    assign cur_wstrb  = w_held  ? wstrb_q  : bus.s_axi_wstrb[STRB_WIDTH-1:0];

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state <= W_COLLECT;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        case (w_state)
            W_COLLECT: begin
                commit = (aw_held || aw_hs) && (w_held || w_hs);
                if (commit) w_next = W_RESP;
            end
            W_RESP:  if (bus.s_axi_bready) w_next = W_COLLECT;
            default: w_next = W_COLLECT;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (bus.s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= OKAY;
            rresp_q  <= OKAY;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= bus.s_axi_awaddr;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= bus.s_axi_wdata;
                wstrb_q <= bus.s_axi_wstrb[STRB_WIDTH-1:0];
            end
            if (commit) bresp_q <= addr_hit(cur_awaddr) ? OKAY : SLVERR;
            if (w_state == W_RESP && bus.s_axi_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (ar_hs) rresp_q <= addr_hit(bus.s_axi_araddr) ? OKAY : SLVERR;
        end
    end

    axi_lite_strb_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_mem (
        .clk   (s_axi_aclk),
        .rst   (s_axi_areset),
        .we    (commit && addr_hit(cur_awaddr)),
        .waddr (addr_index(cur_awaddr)),
        .wdata (cur_wdata),
        .wstrb (cur_wstrb),
        .re    (ar_hs),
        .rhit  (addr_hit(bus.s_axi_araddr)),
        .raddr (addr_index(bus.s_axi_araddr)),
        .rdata (mem_rdata)
    );

    assign bus.s_axi_bvalid = (w_state == W_RESP);
    assign bus.s_axi_bresp  = bresp_q;
    assign bus.s_axi_rvalid = (r_state == R_DATA);
    assign bus.s_axi_rresp  = rresp_q;
    assign bus.s_axi_rdata  = mem_rdata;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// tb/tb_axi_lite_slave_mem.sv - directed bench for two responders (base 0x00 and base 0x10) in lockstep
module tb_axi_lite_slave_mem;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axi_lite_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) bus0 ();
    axi_lite_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) bus1 ();

    assign bus1.s_axi_awaddr  = bus0.s_axi_awaddr;
    assign bus1.s_axi_awvalid = bus0.s_axi_awvalid;
    assign bus1.s_axi_wdata   = bus0.s_axi_wdata;
    assign bus1.s_axi_wstrb   = bus0.s_axi_wstrb;
    assign bus1.s_axi_wvalid  = bus0.s_axi_wvalid;
    assign bus1.s_axi_bready  = bus0.s_axi_bready;
    assign bus1.s_axi_araddr  = bus0.s_axi_araddr;
    assign bus1.s_axi_arvalid = bus0.s_axi_arvalid;
    assign bus1.s_axi_rready  = bus0.s_axi_rready;

    axi_lite_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .DEPTH(16), .BASE_ADDR(0)) dut0 (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .bus          (bus0.slave)
    );

    axi_lite_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .DEPTH(16), .BASE_ADDR(16)) dut1 (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .bus          (bus1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic put_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
        bus0.s_axi_awaddr  = a;
        bus0.s_axi_awvalid = 1'b1;
        bus0.s_axi_wdata   = d;
        bus0.s_axi_wstrb   = s;
        bus0.s_axi_wvalid  = 1'b1;
        tick();
        bus0.s_axi_awvalid = 1'b0;
        bus0.s_axi_wvalid  = 1'b0;
    endtask

    task automatic put_read(input logic [7:0] a);
        bus0.s_axi_araddr  = a;
        bus0.s_axi_arvalid = 1'b1;
        tick();
        bus0.s_axi_arvalid = 1'b0;
    endtask

    task automatic write_chk(input string tag, input logic [7:0] a, input logic [31:0] d,
                             input logic [4:0] s, input logic [2:0] r0, input logic [2:0] r1);
        bus0.s_axi_bready = 1'b1;
        put_write(a, d, s);
        chk({tag, " bvalid"}, 32'(bus0.s_axi_bvalid), 32'd1);
        chk({tag, " bresp0"}, 32'(bus0.s_axi_bresp), 32'(r0));
        chk({tag, " bresp1"}, 32'(bus1.s_axi_bresp), 32'(r1));
        tick();
        chk({tag, " bdone"}, 32'(bus0.s_axi_bvalid), 32'd0);
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] d0,
                            input logic [2:0] r0, input logic [31:0] d1, input logic [2:0] r1);
        bus0.s_axi_rready = 1'b1;
        put_read(a);
        chk({tag, " rvalid"}, 32'(bus0.s_axi_rvalid), 32'd1);
        chk({tag, " rdata0"}, bus0.s_axi_rdata, d0);
        chk({tag, " rresp0"}, 32'(bus0.s_axi_rresp), 32'(r0));
        chk({tag, " rdata1"}, bus1.s_axi_rdata, d1);
        chk({tag, " rresp1"}, 32'(bus1.s_axi_rresp), 32'(r1));
        tick();
        chk({tag, " rdone"}, 32'(bus0.s_axi_rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus0.s_axi_awaddr = '0; bus0.s_axi_awvalid = 1'b0;
        bus0.s_axi_wdata = '0;  bus0.s_axi_wstrb = '0; bus0.s_axi_wvalid = 1'b0;
        bus0.s_axi_bready = 1'b0;
        bus0.s_axi_araddr = '0; bus0.s_axi_arvalid = 1'b0; bus0.s_axi_rready = 1'b0;
        tick();
        tick();
        chk("rst awready", 32'(bus0.s_axi_awready), 32'd0);
        chk("rst wready", 32'(bus0.s_axi_wready), 32'd0);
        chk("rst arready", 32'(bus0.s_axi_arready), 32'd0);
        chk("rst bvalid", 32'(bus0.s_axi_bvalid), 32'd0);
        chk("rst rvalid", 32'(bus0.s_axi_rvalid), 32'd0);
        chk("rst rdata", bus0.s_axi_rdata, 32'd0);
        chk("rst bresp", 32'(bus0.s_axi_bresp), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle awready", 32'(bus0.s_axi_awready), 32'd1);
        chk("idle wready", 32'(bus0.s_axi_wready), 32'd1);
        chk("idle arready", 32'(bus0.s_axi_arready), 32'd1);

        // Same-cycle AW and W
        write_chk("t1 wr", 8'h00, 32'h0000_0038, 5'h0F, 3'b000, 3'b010);
        chk("t1 awready back", 32'(bus0.s_axi_awready), 32'd1);
        read_chk("t1 rd", 8'h00, 32'h0000_0038, 3'b000, 32'h0, 3'b010);

        // W three cycles ahead of AW
        bus0.s_axi_bready = 1'b1;
        bus0.s_axi_wdata  = 32'h1234_5678;
        bus0.s_axi_wstrb  = 5'h0F;
        bus0.s_axi_wvalid = 1'b1;
        tick();
        bus0.s_axi_wvalid = 1'b0;
        chk("t2 wready held", 32'(bus0.s_axi_wready), 32'd0);
        chk("t2 awready open", 32'(bus0.s_axi_awready), 32'd1);
        tick();
        tick();
        chk("t2 no early b", 32'(bus0.s_axi_bvalid), 32'd0);
        bus0.s_axi_awaddr  = 8'h04;
        bus0.s_axi_awvalid = 1'b1;
        tick();
        bus0.s_axi_awvalid = 1'b0;
        chk("t2 bvalid", 32'(bus0.s_axi_bvalid), 32'd1);
        chk("t2 bresp", 32'(bus0.s_axi_bresp), 32'd0);
        tick();
        read_chk("t2 rd", 8'h04, 32'h1234_5678, 3'b000, 32'h0, 3'b010);

        // Partial and MSB-only strobes
        write_chk("t3 full", 8'h08, 32'h1122_3344, 5'h0F, 3'b000, 3'b010);
        write_chk("t3 part", 8'h08, 32'hAABB_CCDD, 5'h05, 3'b000, 3'b010);
        read_chk("t3 rd part", 8'h08, 32'h11BB_33DD, 3'b000, 32'h0, 3'b010);
        write_chk("t3 msb", 8'h08, 32'hFFFF_FFFF, 5'h10, 3'b000, 3'b010);
        read_chk("t3 rd msb", 8'h08, 32'h11BB_33DD, 3'b000, 32'h0, 3'b010);

        // Backpressure on B then on R
        bus0.s_axi_bready = 1'b0;
        put_write(8'h0C, 32'hDEAD_BEEF, 5'h0F);
        for (int i = 0; i < 5; i++) begin
            chk("t4 bvalid hold", 32'(bus0.s_axi_bvalid), 32'd1);
            chk("t4 bresp hold", 32'(bus0.s_axi_bresp), 32'd0);
            chk("t4 awready low", 32'(bus0.s_axi_awready), 32'd0);
            chk("t4 wready low", 32'(bus0.s_axi_wready), 32'd0);
            tick();
        end
        bus0.s_axi_bready = 1'b1;
        tick();
        chk("t4 b released", 32'(bus0.s_axi_bvalid), 32'd0);
        bus0.s_axi_rready = 1'b0;
        put_read(8'h0C);
        for (int i = 0; i < 3; i++) begin
            chk("t4 rvalid hold", 32'(bus0.s_axi_rvalid), 32'd1);
            chk("t4 rdata hold", bus0.s_axi_rdata, 32'hDEAD_BEEF);
            chk("t4 arready low", 32'(bus0.s_axi_arready), 32'd0);
            tick();
        end
        bus0.s_axi_rready = 1'b1;
        tick();
        chk("t4 r released", 32'(bus0.s_axi_rvalid), 32'd0);
        chk("t4 arready back", 32'(bus0.s_axi_arready), 32'd1);

        // Read and write to the same word on the same edge
        bus0.s_axi_araddr  = 8'h0C;
        bus0.s_axi_arvalid = 1'b1;
        put_write(8'h0C, 32'h0102_0304, 5'h0F);
        bus0.s_axi_arvalid = 1'b0;
        chk("rw old data", bus0.s_axi_rdata, 32'hDEAD_BEEF);
        chk("rw bvalid", 32'(bus0.s_axi_bvalid), 32'd1);
        tick();
        read_chk("rw new data", 8'h0C, 32'h0102_0304, 3'b000, 32'h0, 3'b010);

        // Range decode; dut1 decodes 0x10..0x4F
        write_chk("t5 wr 14", 8'h14, 32'hCAFE_F00D, 5'h0F, 3'b000, 3'b000);
        write_chk("t5 wr 00", 8'h00, 32'hFFFF_FFFF, 5'h0F, 3'b000, 3'b010);
        write_chk("t5 wr 50", 8'h50, 32'hFFFF_FFFF, 5'h0F, 3'b010, 3'b010);
        write_chk("t5 wr 4c", 8'h4C, 32'h600D_CAFE, 5'h0F, 3'b010, 3'b000);
        read_chk("t5 rd 14", 8'h14, 32'hCAFE_F00D, 3'b000, 32'hCAFE_F00D, 3'b000);
        read_chk("t5 rd 10", 8'h10, 32'h0, 3'b000, 32'h0, 3'b000);
        read_chk("t5 rd 50", 8'h50, 32'h0, 3'b010, 32'h0, 3'b010);
        read_chk("t5 rd 4f", 8'h4F, 32'h0, 3'b010, 32'h600D_CAFE, 3'b000);
        read_chk("t5 rd 3c", 8'h3C, 32'h0, 3'b000, 32'h0, 3'b000);

        // Reset while both responses are pending
        bus0.s_axi_bready  = 1'b0;
        bus0.s_axi_rready  = 1'b0;
        bus0.s_axi_araddr  = 8'h0C;
        bus0.s_axi_arvalid = 1'b1;
        put_write(8'h04, 32'h7777_7777, 5'h0F);
        bus0.s_axi_arvalid = 1'b0;
        chk("t6 bvalid pre", 32'(bus0.s_axi_bvalid), 32'd1);
        chk("t6 rvalid pre", 32'(bus0.s_axi_rvalid), 32'd1);
        chk("t6 rdata pre", bus0.s_axi_rdata, 32'h0102_0304);
        rst = 1'b1;
        tick();
        chk("t6 bvalid rst", 32'(bus0.s_axi_bvalid), 32'd0);
        chk("t6 rvalid rst", 32'(bus0.s_axi_rvalid), 32'd0);
        chk("t6 rdata rst", bus0.s_axi_rdata, 32'd0);
        chk("t6 awready rst", 32'(bus0.s_axi_awready), 32'd0);
        chk("t6 arready rst", 32'(bus0.s_axi_arready), 32'd0);
        rst = 1'b0;
        bus0.s_axi_bready = 1'b1;
        bus0.s_axi_rready = 1'b1;
        tick();
        read_chk("t6 rd 0c", 8'h0C, 32'h0, 3'b000, 32'h0, 3'b010);
        read_chk("t6 rd 04", 8'h04, 32'h0, 3'b000, 32'h0, 3'b010);
        read_chk("t6 rd 14", 8'h14, 32'h0, 3'b000, 32'h0, 3'b000);
        write_chk("t6 wr", 8'h04, 32'h5A5A_5A5A, 5'h0F, 3'b000, 3'b010);
        read_chk("t6 rd new", 8'h04, 32'h5A5A_5A5A, 3'b000, 32'h0, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
